// File: rtl/pipe_buffer_if.sv
// Valid/ready handshake bundle for pipe_buffer: producer side (in_*) and consumer side (out_*).
// slave is the buffer's view; master is the surrounding pipeline's view.
interface pipe_buffer_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_buffer.sv
// Elastic DEPTH-entry circular buffer between pipeline stages, with flush and occupancy flags.
// Optional zero-latency bypass when empty is enabled by defining PIPE_BUFFER_BYPASS_EN.
module pipe_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  pipe_buffer_if.slave  bus,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             byp;
  logic             push;
  logic             pop_store;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign bus.in_ready = ~full;

`ifdef PIPE_BUFFER_BYPASS_EN
  assign byp = empty & bus.in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign bus.out_valid = ~empty | byp;

  always_comb begin
    bus.out_data = '0;
    if (!empty) begin
      bus.out_data = mem[rd_ptr];
    end else if (byp) begin
      bus.out_data = bus.in_data;
    end
  end

  // A bypassed payload taken by the consumer in the same cycle never touches storage.
  assign push      = bus.in_valid & ~full & ~flush & ~(byp & bus.out_ready);
  assign pop_store = ~empty & bus.out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_store) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop_store);
    end
  end

  // Payload array is never cleared; valid entries are tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench for pipe_buffer (DEPTH=4, WIDTH=64): directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_pipe_buffer;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;

  pipe_buffer_if #(.WIDTH(WIDTH)) bus ();

  pipe_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  bit known = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input bit rst_i, input bit fl_i, input bit iv, input logic [WIDTH-1:0] d,
                       input bit ordy);
    bit m_empty, m_full, m_byp, m_ov;
    logic [WIDTH-1:0] m_od;
    reset = rst_i;
    flush = fl_i;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    #2;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
`ifdef PIPE_BUFFER_BYPASS_EN
    m_byp = m_empty && iv && !fl_i;
`else
    m_byp = 0;
`endif
    m_ov = !m_empty || m_byp;
    m_od = !m_empty ? q[0] : (m_byp ? d : '0);
    if (known) begin
      chk("count", WIDTH'(count), WIDTH'(q.size()));
      chk("full", WIDTH'(full), WIDTH'(m_full));
      chk("empty", WIDTH'(empty), WIDTH'(m_empty));
      chk("in_ready", WIDTH'(bus.in_ready), WIDTH'(!m_full));
      chk("out_valid", WIDTH'(bus.out_valid), WIDTH'(m_ov));
      chk("out_data", bus.out_data, m_od);
    end
    if (!rst_i || fl_i) begin
      q.delete();
      if (!rst_i) known = 1;
    end else begin
      if (m_ov && ordy && !m_empty) void'(q.pop_front());
      if (iv && !m_full && !(m_byp && ordy)) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with in_valid high
    cycle(0, 0, 1, 64'hDEAD, 0);
    cycle(0, 0, 1, 64'hDEAD, 0);
    chk("rst_count", WIDTH'(count), 64'd0);
    chk("rst_empty", WIDTH'(empty), 64'd1);
    chk("rst_full", WIDTH'(full), 64'd0);
    chk("rst_in_ready", WIDTH'(bus.in_ready), 64'd1);
    cycle(1, 0, 0, '0, 0);

    // Fill then drain
    cycle(1, 0, 1, 64'h11, 0);
    cycle(1, 0, 1, 64'h22, 0);
    cycle(1, 0, 1, 64'h33, 0);
    cycle(1, 0, 1, 64'h44, 0);
    chk("fill_count", WIDTH'(count), 64'd4);
    chk("fill_full", WIDTH'(full), 64'd1);
    chk("fill_in_ready", WIDTH'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", bus.out_data, 64'(8'h11 * (i + 1)));
      cycle(1, 0, 0, '0, 1);
    end
    chk("drain_empty", WIDTH'(empty), 64'd1);

    // Streaming across the pointer wrap
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, 1, 64'(i), 1);
`ifndef PIPE_BUFFER_BYPASS_EN
      chk("stream_count", WIDTH'(count), 64'd1);
`endif
    end
    cycle(1, 0, 0, '0, 1);
    chk("stream_empty", WIDTH'(empty), 64'd1);

    // Full with simultaneous pop: push refused, then accepted
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 64'(i + 100), 0);
    cycle(1, 0, 1, 64'h55, 1);
    chk("fullpop_count", WIDTH'(count), 64'd3);
    cycle(1, 0, 1, 64'h55, 0);
    chk("fullpop_accept", WIDTH'(count), 64'd4);

    // Flush priority at count=3
    cycle(1, 0, 0, '0, 1);
    chk("pre_flush_count", WIDTH'(count), 64'd3);
    cycle(1, 1, 1, 64'h77, 1);
    chk("flush_count", WIDTH'(count), 64'd0);
    cycle(1, 0, 0, '0, 0);

    // Bypass / one-cycle latency on an empty buffer
    bus.in_valid = 1'b1;
    bus.in_data = 64'hABCD;
    bus.out_ready = 1'b1;
    #1;
`ifdef PIPE_BUFFER_BYPASS_EN
    chk("byp_valid", WIDTH'(bus.out_valid), 64'd1);
    chk("byp_data", bus.out_data, 64'hABCD);
`else
    chk("nobyp_valid", WIDTH'(bus.out_valid), 64'd0);
`endif
    cycle(1, 0, 1, 64'hABCD, 1);
`ifdef PIPE_BUFFER_BYPASS_EN
    chk("byp_count", WIDTH'(count), 64'd0);
`else
    chk("nobyp_count", WIDTH'(count), 64'd1);
`endif
    cycle(1, 0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0, 1'($urandom),
            {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
